issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Dual-issue instruction queue between decode and the issue/EX register stage.
- Accepts up to two decoded PC_set entries per cycle from decode.
- Presents up to two oldest entries as i_set1/i_set2 to the issue/EX stage, applying the dual-issue pairing rules.
- Drives the four regfile read addresses; the regfile read is combinational, so rdata_a1..b2 line up with i_set1/i_set2 in the same cycle. Pops on no-stall, clears on branch flush.

Parameters:
DEPTH, 8, number of queue entries; power of 2, >= 4
PTR_W, $clog2(DEPTH), read/write pointer width
ALU_TYPE, 10'h001, inst_type code of a simple ALU instruction (the only type allowed in pipe A)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
d_set1  in  PC_set  older decoded instruction; d_set1.o_valid = push request
d_set2  in  PC_set  younger decoded instruction; d_set2.o_valid = push request
d_ready  out  1  queue can accept two entries this cycle
flush_BR  in  1  branch mispredict flush
stall_DCache  in  1  downstream stall; no pop
i_set1  out  PC_set  oldest entry; o_valid = issued
i_set2  out  PC_set  second-oldest entry; o_valid = co-issued
rf_raddr_a1  out  5  i_set1.rf_raddr1
rf_raddr_a2  out  5  i_set1.rf_raddr2
rf_raddr_b1  out  5  i_set2.rf_raddr1
rf_raddr_b2  out  5  i_set2.rf_raddr2
q_count  out  PTR_W+1  occupied entries (debug/perf)

Behaviour:
- Reset:
  - head, tail and count are 0.
  - d_ready=1; q_count=0.
  - i_set1/i_set2 are all-zero with o_valid=0; rf_raddr_* are 0.
  - Entry storage is not reset.
- d_ready = (DEPTH - count) >= 2, computed from registered count only.
- Push:
  - Accepted only when d_ready=1 and flush_BR=0.
  - Valid inputs are written in order and compacted: if only d_set2 is valid, it goes to tail.
  - tail advances by the number of valid inputs, modulo DEPTH.
  - Push while d_ready=0 is ignored; decode must hold its inputs.
- Slot 1 (combinational from head): i_set1.o_valid = (count>=1) & ~flush_BR.
- Slot 2 (combinational from head+1): i_set2.o_valid = (count>=2) & ~flush_BR & pair_ok, where pair_ok is false if any of:
  - RAW: e1.rf_we & e1.rf_rd!=0 & (e1.rf_rd==e2.rf_raddr1 | e1.rf_rd==e2.rf_raddr2)
  - WAW: e1.rf_we & e2.rf_we & e1.rf_rd!=0 & e1.rf_rd==e2.rf_rd
  - structural: e1.inst_type!=ALU_TYPE & e2.inst_type!=ALU_TYPE
- When a slot is invalid, all of its output fields and its rf_raddr_* are forced to 0.
- Pop:
  - When ~stall_DCache & ~flush_BR, head advances by i_set1.o_valid + i_set2.o_valid.
  - While stall_DCache=1, nothing pops and the outputs stay stable; pushes still proceed.
- Count: count_next = count + pushes - pops, in the same cycle. Push and pop together are legal, including when full and when empty.
- Flush:
  - Next cycle head=tail=count=0.
  - A same-cycle push is dropped.
  - Flush has priority over stall.
- Pointers wrap modulo DEPTH; FIFO order is preserved across wrap.
- An overflow is impossible by construction. A bench assertion checks count <= DEPTH.

Decomposition:
- Public_Info package: PC_set struct (existing) plus a new ALU_TYPE constant.
- Sub-module issue_pair_check: combinational, takes two PC_set entries and outputs pair_ok (RAW/WAW/structural rules).

Test Plan:
1. After reset, push ALU pair (PC 0x1c000000 rd=4, PC 0x1c000004 rd=6, raddrs 1/2) -> next cycle both o_valid=1 in order, rf_raddr_a1=1; the following cycle q_count=0.
2. e1 rd=5 rf_we=1 and e2 raddr1=5 -> only i_set1 issues; the next cycle e2 is presented as i_set1 with o_valid=1.
3. Two loads (inst_type 10'h002 each) -> single issue on each of two consecutive cycles. A load followed by an ALU op dual-issues.
4. stall_DCache=1 while pushing 2 per cycle from empty -> q_count 2,4,6,8 and d_ready=0 at 8. Deassert stall -> pops resume, d_ready=1 once count<=6.
5. count=5 with flush_BR=1 and a simultaneous 2-entry push -> same cycle both o_valid=0; next cycle q_count=0 and the pushed entries are lost.
6. Run 20 single-entry pushes (only d_set2 valid, PCs ascending by 4) while popping -> entries are compacted, pointers wrap past DEPTH, and issued PCs are strictly ascending with none lost or duplicated.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared types for the decode -> issue path: the decoded instruction record
// carried between stages and the inst_type code of a simple ALU op.
package issue_queue_pkg;

  // Simple ALU instructions are the only type that may occupy pipe A.
  localparam logic [9:0] ALU_TYPE_CODE = 10'h001;

  typedef struct packed {
    logic        o_valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [9:0]  inst_type;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [4:0]  rf_rd;
    logic        rf_we;
  } PC_set;

endpackage

// File: rtl/issue_pair_check.sv
// Decides whether the second-oldest entry may issue alongside the oldest one.
// Blocks the pair on a RAW or WAW hazard through a non-zero destination, or
// when neither instruction is a simple ALU op (only one non-ALU pipe exists).
module issue_pair_check
  import issue_queue_pkg::*;
#(
  parameter logic [9:0] ALU_TYPE = ALU_TYPE_CODE
) (
  input  PC_set e1,
  input  PC_set e2,
  output logic  pair_ok
);

  logic raw;
  logic waw;
  logic structural;
  logic unused_fields;

  assign raw = e1.rf_we & (e1.rf_rd != 5'd0) &
               ((e1.rf_rd == e2.rf_raddr1) | (e1.rf_rd == e2.rf_raddr2));

  assign waw = e1.rf_we & e2.rf_we & (e1.rf_rd != 5'd0) & (e1.rf_rd == e2.rf_rd);

  assign structural = (e1.inst_type != ALU_TYPE) & (e2.inst_type != ALU_TYPE);

  assign pair_ok = ~(raw | waw | structural);

  // Fields that play no part in the pairing decision.
  assign unused_fields = ^{e1.o_valid, e1.pc, e1.inst, e1.rf_raddr1, e1.rf_raddr2,
                           e2.o_valid, e2.pc, e2.inst};

endmodule

// File: rtl/issue_queue.sv
// Dual-issue instruction queue between decode and the issue/EX register.
// Accepts up to two entries per cycle (compacted at the tail), presents the two
// oldest entries to issue with pairing rules applied, and drives the regfile
// read addresses so the combinational regfile data lines up with i_set1/i_set2.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter int         PTR_W    = $clog2(DEPTH),
  parameter logic [9:0] ALU_TYPE = ALU_TYPE_CODE
) (
  input  logic           clk,
  input  logic           rstn,
  input  PC_set          d_set1,
  input  PC_set          d_set2,
  output logic           d_ready,
  input  logic           flush_BR,
  input  logic           stall_DCache,
  output PC_set          i_set1,
  output PC_set          i_set2,
  output logic [4:0]     rf_raddr_a1,
  output logic [4:0]     rf_raddr_a2,
  output logic [4:0]     rf_raddr_b1,
  output logic [4:0]     rf_raddr_b2,
  output logic [PTR_W:0] q_count
);

  PC_set            mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  PC_set            e1;
  PC_set            e2;
  logic             pair_ok;
  logic             v1;
  logic             v2;
  logic             push_ok;
  logic [1:0]       n_push;
  logic [1:0]       n_pop;
  logic [PTR_W-1:0] tail_2nd;

  // Ready depends on registered occupancy only, so decode sees no comb path
  // back from flush or stall.
  assign d_ready  = (count <= (PTR_W+1)'(DEPTH - 2));
  assign push_ok  = d_ready & ~flush_BR;
  assign n_push   = push_ok ? ({1'b0, d_set1.o_valid} + {1'b0, d_set2.o_valid}) : 2'd0;
  // A lone d_set2 lands at tail itself so the queue stays gap-free.
  assign tail_2nd = tail + PTR_W'(d_set1.o_valid);

  assign e1 = mem[head];
  assign e2 = mem[head + PTR_W'(1)];

  issue_pair_check #(
    .ALU_TYPE (ALU_TYPE)
  ) u_pair_check (
    .e1      (e1),
    .e2      (e2),
    .pair_ok (pair_ok)
  );

  assign v1    = (count != '0) & ~flush_BR;
  assign v2    = (count >= (PTR_W+1)'(2)) & ~flush_BR & pair_ok;
  assign n_pop = (~stall_DCache & ~flush_BR) ? ({1'b0, v1} + {1'b0, v2}) : 2'd0;

  // Issue slots: an invalid slot shows all-zero fields so nothing stale leaks downstream.
  always_comb begin
    i_set1 = '0;
    i_set2 = '0;
    if (v1) begin
      i_set1         = e1;
      i_set1.o_valid = 1'b1;
    end
    if (v2) begin
      i_set2         = e2;
      i_set2.o_valid = 1'b1;
    end
  end

  assign rf_raddr_a1 = i_set1.rf_raddr1;
  assign rf_raddr_a2 = i_set1.rf_raddr2;
  assign rf_raddr_b1 = i_set2.rf_raddr1;
  assign rf_raddr_b2 = i_set2.rf_raddr2;
  assign q_count     = count;

  // Entry storage: written in order at the tail, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      if (d_set1.o_valid) mem[tail] <= d_set1;
      if (d_set2.o_valid) mem[tail_2nd] <= d_set2;
    end
  end

  // Pointers and occupancy; flush empties the queue and wins over stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_BR) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count + (PTR_W+1)'(n_push) - (PTR_W+1)'(n_pop);
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: pairing-rule vector table, stall/fill, flush and
// wrap-around sequences, with an in-order PC scoreboard on the issue side.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int         DEPTH = 8;
  localparam int         PTR_W = $clog2(DEPTH);
  localparam logic [9:0] ALU   = 10'h001;
  localparam logic [9:0] LD    = 10'h002;

  logic           clk = 1'b0;
  logic           rstn;
  PC_set          d_set1, d_set2, i_set1, i_set2;
  logic           d_ready, flush_BR, stall_DCache;
  logic [4:0]     rf_raddr_a1, rf_raddr_a2, rf_raddr_b1, rf_raddr_b2;
  logic [PTR_W:0] q_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_issued = 0;
  logic [31:0] sb[$];
  PC_set       IDLE;

  typedef struct {
    PC_set e1;
    PC_set e2;
    logic  exp_v2;
    string name;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .d_set1       (d_set1),
    .d_set2       (d_set2),
    .d_ready      (d_ready),
    .flush_BR     (flush_BR),
    .stall_DCache (stall_DCache),
    .i_set1       (i_set1),
    .i_set2       (i_set2),
    .rf_raddr_a1  (rf_raddr_a1),
    .rf_raddr_a2  (rf_raddr_a2),
    .rf_raddr_b1  (rf_raddr_b1),
    .rf_raddr_b2  (rf_raddr_b2),
    .q_count      (q_count)
  );

  function automatic PC_set mk(input logic [31:0] pc, input logic [9:0] t,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic we);
    PC_set s;
    s.o_valid   = 1'b1;
    s.pc        = pc;
    s.inst      = ~pc;
    s.inst_type = t;
    s.rf_raddr1 = r1;
    s.rf_raddr2 = r2;
    s.rf_rd     = rd;
    s.rf_we     = we;
    return s;
  endfunction

  // Hazard-free ALU entry with a distinct destination per index.
  function automatic PC_set seqe(input int i);
    return mk(32'h1c001000 + 32'(4 * i), ALU, 5'd1, 5'd2, 5'(8 + (i % 20)), 1'b1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int k, input PC_set a, input PC_set b,
                         input logic ev2, input string nm);
    vecs[k].e1     = a;
    vecs[k].e2     = b;
    vecs[k].exp_v2 = ev2;
    vecs[k].name   = nm;
  endtask

  // One cycle: drive just after the rising edge, record accepted pushes in the
  // scoreboard, return at the falling edge where outputs are checked.
  task automatic cyc(input PC_set a, input PC_set b, input logic st, input logic fl);
    @(posedge clk);
    #1;
    d_set1       = a;
    d_set2       = b;
    stall_DCache = st;
    flush_BR     = fl;
    if (fl) begin
      sb.delete();
    end else if (d_ready) begin
      if (a.o_valid) sb.push_back(a.pc);
      if (b.o_valid) sb.push_back(b.pc);
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((q_count != '0) && (k < 30)) begin
      cyc(IDLE, IDLE, 1'b0, 1'b0);
      k++;
    end
    #1;
    chk({name, "/drained_q_count"}, q_count, 0);
    chk({name, "/scoreboard_empty"}, sb.size(), 0);
  endtask

  task automatic sb_pop(input string name, input logic [31:0] pc);
    n_checks++;
    n_issued++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: issued pc %0h but nothing expected", name, pc);
    end else begin
      logic [31:0] e;
      e = sb.pop_front();
      if (pc !== e) begin
        n_fail++;
        $display("FAIL %s: issued pc %0h expected %0h", name, pc, e);
      end
    end
  endtask

  // Issue-side monitor: every popped entry must be the next expected PC.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      n_checks++;
      assert (q_count <= (PTR_W+1)'(DEPTH))
      else begin
        n_fail++;
        $display("FAIL count_bound: q_count %0d above %0d", q_count, DEPTH);
      end
      if (i_set2.o_valid && !i_set1.o_valid) begin
        n_fail++;
        $display("FAIL slot_order: i_set2 valid %0b with i_set1 valid %0b", i_set2.o_valid, i_set1.o_valid);
      end
      if (!stall_DCache && !flush_BR) begin
        if (i_set1.o_valid) sb_pop("issue_slot1", i_set1.pc);
        if (i_set2.o_valid) sb_pop("issue_slot2", i_set2.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int issued0;
    IDLE         = '0;
    rstn         = 1'b0;
    d_set1       = '0;
    d_set2       = '0;
    flush_BR     = 1'b0;
    stall_DCache = 1'b0;

    set_vec(0, mk(32'h1c000000, ALU, 5'd1, 5'd2, 5'd4, 1'b1),
               mk(32'h1c000004, ALU, 5'd1, 5'd2, 5'd6, 1'b1), 1'b1, "alu_pair");
    set_vec(1, mk(32'h1c000010, ALU, 5'd1, 5'd2, 5'd5, 1'b1),
               mk(32'h1c000014, ALU, 5'd5, 5'd3, 5'd7, 1'b1), 1'b0, "raw_raddr1");
    set_vec(2, mk(32'h1c000020, ALU, 5'd1, 5'd2, 5'd9, 1'b1),
               mk(32'h1c000024, ALU, 5'd3, 5'd9, 5'd10, 1'b1), 1'b0, "raw_raddr2");
    set_vec(3, mk(32'h1c000030, ALU, 5'd1, 5'd2, 5'd5, 1'b0),
               mk(32'h1c000034, ALU, 5'd5, 5'd3, 5'd7, 1'b1), 1'b1, "raw_no_we");
    set_vec(4, mk(32'h1c000040, ALU, 5'd1, 5'd2, 5'd0, 1'b1),
               mk(32'h1c000044, ALU, 5'd0, 5'd0, 5'd0, 1'b1), 1'b1, "rd_zero");
    set_vec(5, mk(32'h1c000050, ALU, 5'd1, 5'd2, 5'd12, 1'b1),
               mk(32'h1c000054, ALU, 5'd1, 5'd2, 5'd12, 1'b1), 1'b0, "waw");
    set_vec(6, mk(32'h1c000060, LD, 5'd1, 5'd2, 5'd13, 1'b1),
               mk(32'h1c000064, LD, 5'd1, 5'd2, 5'd14, 1'b1), 1'b0, "two_loads");
    set_vec(7, mk(32'h1c000070, LD, 5'd1, 5'd2, 5'd15, 1'b1),
               mk(32'h1c000074, ALU, 5'd2, 5'd3, 5'd16, 1'b1), 1'b1, "load_alu");
    set_vec(8, mk(32'h1c000080, ALU, 5'd1, 5'd2, 5'd17, 1'b1),
               mk(32'h1c000084, LD, 5'd3, 5'd4, 5'd18, 1'b1), 1'b1, "alu_load");

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset/d_ready", d_ready, 1);
    chk("reset/q_count", q_count, 0);
    chk("reset/i_set1_valid", i_set1.o_valid, 0);
    chk("reset/i_set1_pc", i_set1.pc, 0);
    chk("reset/i_set2_valid", i_set2.o_valid, 0);
    chk("reset/rf_raddr_a1", rf_raddr_a1, 0);
    chk("reset/rf_raddr_b2", rf_raddr_b2, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Pairing rules: push a pair into an empty queue, check what issues.
    for (int k = 0; k < 9; k++) begin
      cyc(vecs[k].e1, vecs[k].e2, 1'b0, 1'b0);
      cyc(IDLE, IDLE, 1'b0, 1'b0);
      chk({vecs[k].name, "/v1"}, i_set1.o_valid, 1);
      chk({vecs[k].name, "/pc1"}, i_set1.pc, vecs[k].e1.pc);
      chk({vecs[k].name, "/ra1"}, rf_raddr_a1, vecs[k].e1.rf_raddr1);
      chk({vecs[k].name, "/ra2"}, rf_raddr_a2, vecs[k].e1.rf_raddr2);
      chk({vecs[k].name, "/v2"}, i_set2.o_valid, vecs[k].exp_v2);
      chk({vecs[k].name, "/rb1"}, rf_raddr_b1, vecs[k].exp_v2 ? vecs[k].e2.rf_raddr1 : 5'd0);
      chk({vecs[k].name, "/rb2"}, rf_raddr_b2, vecs[k].exp_v2 ? vecs[k].e2.rf_raddr2 : 5'd0);
      if (vecs[k].exp_v2) begin
        chk({vecs[k].name, "/pc2"}, i_set2.pc, vecs[k].e2.pc);
      end else begin
        cyc(IDLE, IDLE, 1'b0, 1'b0);
        chk({vecs[k].name, "/late_v1"}, i_set1.o_valid, 1);
        chk({vecs[k].name, "/late_pc1"}, i_set1.pc, vecs[k].e2.pc);
        chk({vecs[k].name, "/late_v2"}, i_set2.o_valid, 0);
      end
      cyc(IDLE, IDLE, 1'b0, 1'b0);
      chk({vecs[k].name, "/q_count_after"}, q_count, 0);
    end
    drain("pairs");

    // Fill under stall, then release
    for (int k = 0; k < 4; k++) begin
      cyc(seqe(2 * k), seqe(2 * k + 1), 1'b1, 1'b0);
      chk("stall_fill/q_count", q_count, 2 * k);
    end
    cyc(seqe(8), seqe(9), 1'b1, 1'b0);
    chk("stall_full/q_count", q_count, 8);
    chk("stall_full/d_ready", d_ready, 0);
    chk("stall_full/pc1_stable", i_set1.pc, seqe(0).pc);
    cyc(IDLE, IDLE, 1'b0, 1'b0);
    chk("stall_release/q_count", q_count, 8);
    chk("stall_release/d_ready", d_ready, 0);
    cyc(IDLE, IDLE, 1'b0, 1'b0);
    chk("stall_pop/q_count", q_count, 6);
    chk("stall_pop/d_ready", d_ready, 1);
    drain("stall");

    // Flush at count 5 with a simultaneous push (and stall, which flush overrides)
    issued0 = n_issued;
    cyc(seqe(20), seqe(21), 1'b1, 1'b0);
    cyc(seqe(22), seqe(23), 1'b1, 1'b0);
    cyc(IDLE, seqe(24), 1'b1, 1'b0);
    cyc(seqe(25), seqe(26), 1'b1, 1'b1);
    chk("flush/q_count_before", q_count, 5);
    chk("flush/v1", i_set1.o_valid, 0);
    chk("flush/v2", i_set2.o_valid, 0);
    chk("flush/ra1", rf_raddr_a1, 0);
    cyc(IDLE, IDLE, 1'b0, 1'b0);
    chk("flush/q_count_after", q_count, 0);
    chk("flush/v1_after", i_set1.o_valid, 0);
    chk("flush/d_ready_after", d_ready, 1);
    cyc(IDLE, IDLE, 1'b0, 1'b0);
    chk("flush/still_empty", q_count, 0);
    chk("flush/nothing_issued", n_issued - issued0, 0);
    drain("flush");

    // Single d_set2 pushes while popping, wrapping the pointers
    issued0 = n_issued;
    for (int i = 0; i < 20; i++) begin
      cyc(IDLE, seqe(40 + i), 1'b0, 1'b0);
    end
    drain("wrap");
    chk("wrap/issued_count", n_issued - issued0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
